// File: rtl/m10k_port_arbiter_pkg.sv
// Shared constants, requester IDs and arbiter state encoding for the M10K port arbiter.
package m10k_port_arbiter_pkg;

  localparam int ADDRESS_SIZE = 9;
  localparam int ROW_SIZE     = 128;

  localparam int REQ_HPS = 0;
  localparam int REQ_RD  = 1;
  localparam int REQ_WR  = 2;

  // Index width that stays legal for a single requester as well.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(3);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/m10k_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after start_i, wrapping.
module m10k_port_arbiter_rr_pick
  import m10k_port_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  start_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [IDW-1:0] scan_idx;
  logic           found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    scan_idx = start_i;
    for (int n = 0; n < NREQ; n++) begin
      if (!found && req_i[scan_idx]) begin
        found           = 1'b1;
        idx_o           = scan_idx;
        gnt_o[scan_idx] = 1'b1;
      end
      scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
    any_o = found;
  end

endmodule

// File: rtl/m10k_port_arbiter.sv
// Round-robin arbiter sharing one M10K port among NREQ requesters with bounded bursts;
// read data is steered back to the issuing requester RD_LAT cycles after issue.
module m10k_port_arbiter
  import m10k_port_arbiter_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int ADDRESS_SIZE = m10k_port_arbiter_pkg::ADDRESS_SIZE,
  parameter int ROW_SIZE     = m10k_port_arbiter_pkg::ROW_SIZE,
  parameter int BURST_MAX    = 8,
  parameter int RD_LAT       = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NREQ-1:0]              i_req,
  input  logic [NREQ-1:0]              i_we,
  input  logic [NREQ*ADDRESS_SIZE-1:0] i_addr,
  input  logic [NREQ*ROW_SIZE-1:0]     i_wdata,
  output logic [NREQ-1:0]              o_gnt,
  output logic [ADDRESS_SIZE-1:0]      o_mem_addr,
  output logic                         o_mem_wr_en,
  output logic [ROW_SIZE-1:0]          o_mem_wdata,
  input  logic [ROW_SIZE-1:0]          i_mem_rdata,
  output logic [NREQ-1:0]              o_rvalid,
  output logic [ROW_SIZE-1:0]          o_rdata,
  output logic                         o_busy
);

  localparam int              IDW  = id_width(NREQ);
  localparam logic [IDW-1:0]  LAST = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);
  localparam logic [7:0]      BMAX = 8'(BURST_MAX);

  arb_state_e     state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] last_q;
  logic [7:0]     cnt_q;

  logic [NREQ-1:0] owner_oh;
  logic            own_req;
  logic            others_pend;
  logic            hold;
  logic [IDW-1:0]  pick_base;
  logic [IDW-1:0]  pick_start;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_vld;

  assign owner_oh    = ONE << owner_q;
  assign own_req     = i_req[owner_q];
  assign others_pend = |(i_req & ~owner_oh);
  // Owner keeps the port until its burst expires, unless nobody else is waiting.
  assign hold        = (state_q == ST_OWN) && own_req && ((cnt_q < BMAX) || !others_pend);

  assign pick_base  = (state_q == ST_OWN) ? owner_q : last_q;
  assign pick_start = (pick_base == LAST) ? '0 : pick_base + 1'b1;

  m10k_port_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i   (i_req),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign o_gnt   = hold ? owner_oh : pick_gnt;
  assign gnt_idx = hold ? owner_q : pick_idx;
  assign gnt_vld = hold | pick_any;

  assign o_mem_addr  = gnt_vld ? i_addr[gnt_idx*ADDRESS_SIZE +: ADDRESS_SIZE] : '0;
  assign o_mem_wdata = gnt_vld ? i_wdata[gnt_idx*ROW_SIZE +: ROW_SIZE] : '0;
  assign o_mem_wr_en = gnt_vld & i_we[gnt_idx];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_OWN;
            owner_q <= pick_idx;
            cnt_q   <= 8'd1;
          end
        end
        ST_OWN: begin
          if (hold) begin
            cnt_q <= (cnt_q < BMAX) ? cnt_q + 8'd1 : 8'd1;
          end else if (pick_any) begin
            owner_q <= pick_idx;
            last_q  <= owner_q;
            cnt_q   <= 8'd1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // One-hot return tags; the last stage is the registered rvalid.
  logic [NREQ-1:0] rd_pipe_q [RD_LAT];
  logic            pipe_any;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_pipe_q[0] <= o_gnt & ~i_we;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_any = pipe_any | (|rd_pipe_q[i]);
  end

  assign o_rvalid = rd_pipe_q[RD_LAT-1];
  assign o_rdata  = i_mem_rdata;
  assign o_busy   = (|o_gnt) | pipe_any;

endmodule

// File: tb/tb_m10k_port_arbiter.sv
// Randomized and directed bench for m10k_port_arbiter against a queue-based reference model.
module tb_m10k_port_arbiter;

  localparam int N  = 3;
  localparam int AS = 9;
  localparam int RS = 128;
  localparam int BM = 8;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req, we;
  logic [N*AS-1:0] addr;
  logic [N*RS-1:0] wdata;
  logic [RS-1:0]   rd1, rd2;
  logic [N-1:0]    gnt, rvalid;
  logic [AS-1:0]   mem_addr;
  logic            mem_wr_en, busy;
  logic [RS-1:0]   mem_wdata, rdata;

  m10k_port_arbiter #(
    .NREQ(N), .ADDRESS_SIZE(AS), .ROW_SIZE(RS), .BURST_MAX(BM), .RD_LAT(RL)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(rd2), .o_rvalid(rvalid), .o_rdata(rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            id;
    logic [RS-1:0] data;
  } rd_t;

  rd_t           exp_q[$];
  logic [RS-1:0] dmem   [512];
  logic [RS-1:0] shadow [512];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int m_owner, m_lw, m_cnt, n_owner, n_lw, n_cnt;

  task automatic check(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int scan(input logic [N-1:0] r, input int from);
    for (int n = 0; n < N; n++) if (r[(from + n) % N]) return (from + n) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_lw = N - 1; m_cnt = 0;
    exp_q.delete();
  endtask

  // Winner for this cycle plus the arbitration state it leaves behind.
  task automatic decide(output int w);
    n_owner = m_owner; n_lw = m_lw; n_cnt = m_cnt;
    if (m_owner < 0) begin
      w = scan(req, (m_lw + 1) % N);
      n_owner = w;
      n_cnt = (w >= 0) ? 1 : 0;
    end else if (req[m_owner] && (m_cnt < BM || (req & ~(N'(1) << m_owner)) == 0)) begin
      w = m_owner;
      n_cnt = (m_cnt < BM) ? m_cnt + 1 : 1;
    end else begin
      w = scan(req, (m_owner + 1) % N);
      if (w >= 0) begin
        n_owner = w; n_cnt = 1; n_lw = m_owner;
      end else begin
        n_owner = -1; n_cnt = 0;
      end
    end
  endtask

  task automatic step();
    int w;
    logic [N-1:0]  eg, erv;
    logic [RS-1:0] erd, sd;
    logic [AS-1:0] sa;
    logic          eb, sw;
    @(negedge clk);
    if (!rstn) model_reset();
    decide(w);
    eg = (w >= 0) ? (N'(1) << w) : '0;
    check("gnt", RS'(gnt), RS'(eg));
    check("mem_addr", RS'(mem_addr), (w >= 0) ? RS'(addr[w*AS +: AS]) : '0);
    check("mem_wr_en", RS'(mem_wr_en), (w >= 0) ? RS'(we[w]) : '0);
    check("mem_wdata", mem_wdata, (w >= 0) ? wdata[w*RS +: RS] : '0);
    eb = (eg != 0) || (exp_q.size() > 0);
    erv = '0; erd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      erv = N'(1) << exp_q[0].id;
      erd = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rvalid", RS'(rvalid), RS'(erv));
    if (erv != 0) check("rdata", rdata, erd);
    check("busy", RS'(busy), RS'(eb));
    if (w >= 0) begin
      if (we[w]) shadow[addr[w*AS +: AS]] = wdata[w*RS +: RS];
      else exp_q.push_back('{cyc + RL, w, shadow[addr[w*AS +: AS]]});
    end
    sa = mem_addr; sd = mem_wdata; sw = mem_wr_en;
    @(posedge clk);
    rd2 = rd1;
    rd1 = dmem[sa];
    if (sw) dmem[sa] = sd;
    if (rstn) begin
      m_owner = n_owner; m_lw = n_lw; m_cnt = n_cnt;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic set_acc(input int k, input logic w, input logic [AS-1:0] a, input logic [RS-1:0] d);
    we[k] = w;
    addr[k*AS +: AS] = a;
    wdata[k*RS +: RS] = d;
  endtask

  initial begin
    rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; rd1 = '0; rd2 = '0;
    for (int a = 0; a < 512; a++) begin
      dmem[a]   = {4{32'(a) * 32'h9E37_79B1}};
      shadow[a] = dmem[a];
    end
    model_reset();
    step(); step();
    rstn = 1'b1;

    // single read from requester 1
    set_acc(1, 1'b0, 9'd5, '0);
    req = 3'b010;
    #1 check("single_gnt", RS'(gnt), RS'(3'b010));
    step();
    req = '0;
    repeat (4) step();

    // full contention: 8-cycle bursts in order 0,1,2,0
    do_reset();
    for (int k = 0; k < N; k++) set_acc(k, 1'b0, 9'(10 + k), '0);
    req = 3'b111;
    for (int i = 0; i < 26; i++) begin
      #1 check("contend_order", RS'(gnt), RS'(N'(1) << ((i / BM) % N)));
      step();
    end
    req = '0;
    repeat (3) step();

    // early release hands over to 2; last winner 0 lets 1 beat 0 later
    do_reset();
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1 check("early_hold", RS'(gnt), RS'(3'b001));
      step();
    end
    req = 3'b100;
    #1 check("early_handover", RS'(gnt), RS'(3'b100));
    repeat (2) step();
    req = '0;
    repeat (3) step();
    req = 3'b011;
    #1 check("rr_after_release", RS'(gnt), RS'(3'b010));
    step();
    req = '0;
    repeat (3) step();

    // sole requester never loses the grant across burst rollovers
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      #1 check("sole_gnt", RS'(gnt), RS'(3'b010));
      step();
    end
    req = '0;
    repeat (3) step();

    // write from 0 then read-back from 1
    do_reset();
    set_acc(0, 1'b1, 9'd3, {16{8'hA5}});
    set_acc(1, 1'b0, 9'd3, '0);
    req = 3'b001;
    step();
    req = 3'b010;
    step();
    req = '0;
    step();
    check("rw_rvalid", RS'(rvalid), RS'(3'b010));
    check("rw_rdata", rdata, {16{8'hA5}});
    repeat (2) step();

    // reset right after a read issue discards it
    do_reset();
    set_acc(0, 1'b0, 9'd7, '0);
    req = 3'b001;
    step();
    req = '0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    repeat (4) step();
    req = 3'b111;
    #1 check("post_reset_first", RS'(gnt), RS'(3'b001));
    step();
    req = '0;
    repeat (3) step();

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if ($urandom_range(5) == 0) req[k] = 1'b0;
        end else if ($urandom_range(3) == 0) req[k] = 1'b1;
        set_acc(k, ($urandom_range(2) == 0), 9'($urandom_range(15)),
                {$urandom, $urandom, $urandom, $urandom});
      end
      if (i == 700) begin
        req = '0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
      end else begin
        step();
      end
    end
    req = '0;
    repeat (RL + 2) step();
    check("drain_empty", RS'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
